// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if : bundle between the pipeline stages and the stall/flush
//                controller.
//   stall_o   [STAGES]    stall request raised by each stage
//   flush_req [FLUSH_SRC] flush pulses (bp_update, bp_miss, excp, modify_state)
//   set_idle              IDLE instruction committed
//   clr_idle              wake (interrupt taken)
//   stall_i   [STAGES]    stall applied to each stage
//   flush_i   [STAGES]    flush applied to each stage
//   idle_o                core is idle
//   hang_o                sticky stall watchdog flag
// Modports: master = pipeline side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int STAGES    = 7,
  parameter int FLUSH_SRC = 4
);
  logic [STAGES-1:0]    stall_o;
  logic [FLUSH_SRC-1:0] flush_req;
  logic                 set_idle;
  logic                 clr_idle;
  logic [STAGES-1:0]    stall_i;
  logic [STAGES-1:0]    flush_i;
  logic                 idle_o;
  logic                 hang_o;

  modport master (
    output stall_o, flush_req, set_idle, clr_idle,
    input  stall_i, flush_i, idle_o, hang_o
  );

  modport slave (
    input  stall_o, flush_req, set_idle, clr_idle,
    output stall_i, flush_i, idle_o, hang_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : pipeline stall/flush controller for the in-order core.
//   Builds the stall ripple (an older stage stalling holds every younger one),
//   maps flush sources onto stages through FLUSH_MASK (optionally delaying a
//   source by one register), tracks the RUN/IDLE state and runs a stall
//   watchdog.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : pipe_ctrl_if.slave (stall_o, flush_req, set_idle, clr_idle in;
//          stall_i, flush_i, idle_o, hang_o out)
// Optional feature, macro PIPE_CTRL_PERF_EN:
//   perf_stall_cnt [STAGES*32]    cycles with stall_i[i] = 1, per stage
//   perf_flush_cnt [FLUSH_SRC*32] cycles with effective flush s, per source
//   Both saturate at 32'hFFFFFFFF and clear on rst.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int                              STAGES      = 7,
  parameter int                              FLUSH_SRC   = 4,
  parameter logic [FLUSH_SRC*STAGES-1:0]     FLUSH_MASK  = 28'h1E7C781,
  parameter logic [FLUSH_SRC-1:0]            FLUSH_REG   = 4'b0000,
  parameter int                              WDOG_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  pipe_ctrl_if.slave                  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [STAGES*32-1:0]        perf_stall_cnt,
  output logic [FLUSH_SRC*32-1:0]     perf_flush_cnt
`endif
);

  localparam int                CNT_W   = $clog2(WDOG_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WDOG_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_IDLE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FLUSH_SRC-1:0]  r_flush_req;
  logic [FLUSH_SRC-1:0]  w_eff;
  logic [STAGES-1:0]     w_stall;
  logic [STAGES-1:0]     w_flush;
  logic [CNT_W-1:0]      r_wdog_cnt;
  logic                  r_hang;
  logic                  w_idle;
  logic                  w_wdog_run;

  assign w_idle = (r_state == ST_IDLE);

  // Stall ripple and flush mapping (combinational)
  always_comb begin
    w_stall = '0;
    for (int i = 0; i < STAGES - 1; i++) begin
      for (int j = i + 1; j < STAGES; j++) begin
        w_stall[i] = w_stall[i] | bus.stall_o[j];
      end
    end
    // Idle holds fetch only; the rest of the pipe drains normally.
    w_stall[0] = w_stall[0] | w_idle;
  end

  always_comb begin
    w_eff   = '0;
    w_flush = '0;
    for (int s = 0; s < FLUSH_SRC; s++) begin
      w_eff[s] = FLUSH_REG[s] ? r_flush_req[s] : bus.flush_req[s];
      for (int i = 0; i < STAGES; i++) begin
        w_flush[i] = w_flush[i] | (w_eff[s] & FLUSH_MASK[s*STAGES+i]);
      end
    end
  end

  // Stall and flush both leave unmodified; each stage resolves the priority.
  assign bus.stall_i = rst ? '0 : w_stall;
  assign bus.flush_i = rst ? '1 : w_flush;
  assign bus.idle_o  = w_idle;
  assign bus.hang_o  = r_hang;

  // Registered flush sources: deliberately not gated by stall
  always_ff @(posedge clk) begin
    if (rst) r_flush_req <= '0;
    else     r_flush_req <= bus.flush_req;
  end

  // Idle FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (bus.set_idle) w_state_nxt = ST_IDLE;
      ST_IDLE: if (bus.clr_idle && !bus.set_idle) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Watchdog: counts consecutive non-idle stall cycles, saturating at
  // WDOG_CYCLES-1; a further stall cycle at saturation raises hang.
  assign w_wdog_run = (|bus.stall_o) && !w_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_hang     <= 1'b0;
    end else if (!w_wdog_run) begin
      r_wdog_cnt <= '0;
    end else if (r_wdog_cnt == CNT_MAX) begin
      r_hang     <= 1'b1;
    end else begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall [STAGES];
  logic [31:0] r_perf_flush [FLUSH_SRC];

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst)
        r_perf_stall[i] <= '0;
      else if (bus.stall_i[i] && (r_perf_stall[i] != 32'hFFFF_FFFF))
        r_perf_stall[i] <= r_perf_stall[i] + 32'd1;
    end
    for (int s = 0; s < FLUSH_SRC; s++) begin
      if (rst)
        r_perf_flush[s] <= '0;
      else if (w_eff[s] && (r_perf_flush[s] != 32'hFFFF_FFFF))
        r_perf_flush[s] <= r_perf_flush[s] + 32'd1;
    end
  end

  always_comb begin
    perf_stall_cnt = '0;
    perf_flush_cnt = '0;
    for (int i = 0; i < STAGES; i++)    perf_stall_cnt[i*32 +: 32] = r_perf_stall[i];
    for (int s = 0; s < FLUSH_SRC; s++) perf_flush_cnt[s*32 +: 32] = r_perf_flush[s];
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline stall/flush controller for the in-order core; replaces the hand-written stall chain, flush ORs and idle register in the CPU top level.
- Takes per-stage stall requests, N flush sources with a per-source stage mask, and idle set/clear.
- Produces per-stage stall_i/flush_i, optional one-cycle-registered flush sources, and a stall watchdog.

Parameters:
- STAGES, 7, number of pipeline stages; index 0 = IF1, STAGES-1 = WB.
- FLUSH_SRC, 4, number of flush sources.
- FLUSH_MASK, 28'h1E7C781, FLUSH_SRC*STAGES bits. Bit s*STAGES+i = source s flushes stage i. Default: src0 {IF1}, src1 {IF1..EX}, src2 {IF1..MEM1}, src3 {IF1..EX}.
- FLUSH_REG, 4'b0000, bit s = 1 delays source s by one register stage.
- WDOG_CYCLES, 1024, consecutive stall cycles before hang_o asserts; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_o  in  STAGES  per-stage stall request from each stage
- flush_req  in  FLUSH_SRC  flush pulses (bp_update, bp_miss, excp, modify_state)
- set_idle  in  1  IDLE instruction committed
- clr_idle  in  1  wake (interrupt taken)
- stall_i  out  STAGES  stall to each stage
- flush_i  out  STAGES  flush to each stage
- idle_o  out  1  core is in idle state
- hang_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge) clears: idle state → RUN, registered flushes, watchdog counter, hang_o, perf counters.
- While rst is high: stall_i = 0 and flush_i = all ones (combinational on rst).
- Stall chain (combinational):
  - stall_i[STAGES-1] = 0.
  - stall_i[i] = OR of stall_o[j] for j > i. This is a ripple: one upstream stall stalls all younger stages.
  - stall_i[0] additionally ORs idle_o.
- Flush:
  - eff[s] = flush_req[s] if FLUSH_REG[s] = 0, otherwise flush_req[s] registered one cycle. The register is cleared by rst only and is unaffected by stalls.
  - flush_i[i] = OR over s of (eff[s] & FLUSH_MASK[s*STAGES+i]).
  - Flush does not gate stall. Each stage gives flush priority over stall internally. This block outputs both unmodified.
- Idle FSM, states RUN and IDLE:
  - RUN → IDLE on set_idle.
  - IDLE → RUN on clr_idle && !set_idle.
  - set_idle and clr_idle in the same cycle: set wins, state = IDLE.
  - clr_idle in RUN: ignored.
  - idle_o = (state == IDLE), registered; it asserts the cycle after set_idle.
  - Flushes during IDLE do not leave IDLE.
- Watchdog:
  - Counter of width $clog2(WDOG_CYCLES)+1.
  - Increments each cycle (|stall_o) is 1 and idle_o is 0; resets to 0 on any cycle without stall, or while idle.
  - When the counter reaches WDOG_CYCLES-1 and the stall is still present, hang_o ← 1 on the next edge. The counter saturates.
  - hang_o is sticky until rst.
- All outputs other than idle_o and hang_o are combinational; 0-cycle latency from stall_o and from unregistered flush_req.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds ports:
  - perf_stall_cnt  out  STAGES*32: per-stage count of cycles with stall_i[i] = 1.
  - perf_flush_cnt  out  FLUSH_SRC*32: per-source count of cycles with eff[s] = 1.
- Counters are 32-bit, saturate at 32'hFFFFFFFF, reset to 0.
- When undefined: ports absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles with stall_o = 7'h7F and flush_req = 4'hF → stall_i = 0, flush_i = 7'h7F, idle_o = 0, hang_o = 0. After release, idle_o = 0.
- Stall ripple: stall_o = 7'b0010000 (MEM1) → stall_i = 7'b0001111. Adding stall_o[6] → stall_i = 7'b0111111, with stall_i[6] = 0.
- Flush masks, default params: flush_req = 4'b0001 → flush_i = 7'b0000001. 4'b0100 → 7'b0011111. 4'b0011 → 7'b0001111. With FLUSH_REG = 4'b0100, excp pulse at cycle t → flush_i = 7'b0011111 at t+1 only.
- Idle:
  - set_idle pulse → idle_o = 1 next cycle, stall_i[0] = 1.
  - set_idle and clr_idle together → stays IDLE.
  - clr_idle alone → idle_o = 0 next cycle.
  - flush_req = 4'b0100 while idle → idle_o stays 1.
- Watchdog, WDOG_CYCLES = 8:
  - stall_o[5] held 8 cycles → hang_o = 1 after the 8th edge and stays 1 after stall drops.
  - 7 stall cycles then 1 free cycle → hang_o = 0.
- PIPE_CTRL_PERF_EN defined: 5 stall cycles on stage 3 → perf_stall_cnt[0..2] = 5, [3..6] = 0. Counter preloaded to 32'hFFFFFFFE with 3 more cycles → 32'hFFFFFFFF.
